// File: rtl/pipelined_control_unit_if.sv
// ID-stage request and ID/EX control bundle between the front end and the control unit.
interface pipelined_control_unit_if #(
    parameter int OPCODE_W = 6,
    parameter int CMD_W    = 4
);
    logic                in_valid;
    logic [OPCODE_W-1:0] opcode;
    logic                stall_in;
    logic                flush;
    logic                busy;
    logic                ex_valid;
    logic [CMD_W-1:0]    ex_cmd;
    logic                ex_wb_en;
    logic                ex_mem_read;
    logic                ex_mem_write;
    logic                ex_branch;
    logic                ex_illegal;

    modport master (
        output in_valid, opcode, stall_in, flush,
        input  busy, ex_valid, ex_cmd, ex_wb_en, ex_mem_read, ex_mem_write,
               ex_branch, ex_illegal
    );

    modport slave (
        input  in_valid, opcode, stall_in, flush,
        output busy, ex_valid, ex_cmd, ex_wb_en, ex_mem_read, ex_mem_write,
               ex_branch, ex_illegal
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// Opcode decoder feeding the ID/EX register, with stall/flush and a multi-cycle MUL sequencer.
module pipelined_control_unit #(
    parameter int OPCODE_W    = 6,
    parameter int CMD_W       = 4,
    parameter int MUL_LATENCY = 3,
    parameter int MUL_OPCODE  = 13
) (
    input logic clk,
    input logic rst,
    pipelined_control_unit_if.slave bus
);
    localparam int CNT_W = 4;
    localparam logic [CMD_W-1:0] CMD_NOP = '1;
    localparam logic [CMD_W-1:0] CMD_MUL = CMD_W'(MUL_OPCODE);

    typedef enum logic {IDLE, MUL} state_t;

    typedef struct packed {
        logic [CMD_W-1:0] cmd;
        logic             wb_en;
        logic             mem_read;
        logic             mem_write;
        logic             branch;
        logic             illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_CLR = '{cmd: CMD_NOP, default: 1'b0};
    localparam ctrl_t CTRL_MUL = '{cmd: CMD_MUL, wb_en: 1'b1, default: 1'b0};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    ctrl_t            ctrl_q, ctrl_d;
    ctrl_t            dec;
    logic             is_mul;
    logic             accept;

    always_comb begin
        dec    = '{cmd: '0, default: 1'b0};
        is_mul = 1'b0;
        if (bus.opcode == OPCODE_W'(MUL_OPCODE)) begin
            is_mul    = 1'b1;
            dec       = CTRL_MUL;
        end else if (bus.opcode == '0) begin
            dec.cmd   = '0;
        end else if (bus.opcode <= OPCODE_W'(12)) begin
            dec.cmd   = bus.opcode[CMD_W-1:0];
            dec.wb_en = 1'b1;
        end else if (bus.opcode == OPCODE_W'(32)) begin
            dec.cmd      = CMD_W'(1);
            dec.mem_read = 1'b1;
            dec.wb_en    = 1'b1;
        end else if (bus.opcode == OPCODE_W'(33)) begin
            dec.cmd       = CMD_W'(1);
            dec.mem_write = 1'b1;
        end else if (bus.opcode == OPCODE_W'(40)) begin
            dec.cmd    = CMD_W'(2);
            dec.branch = 1'b1;
        end else if (bus.opcode == OPCODE_W'(41)) begin
            dec.cmd    = '0;
            dec.branch = 1'b1;
        end else begin
            dec = '{cmd: CMD_NOP, illegal: 1'b1, default: 1'b0};
        end
    end

    assign accept = bus.in_valid & (state_q == IDLE) & ~bus.stall_in & ~bus.flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            ctrl_d  = CTRL_CLR;
        end else if (!bus.stall_in) begin
            unique case (state_q)
                IDLE: begin
                    valid_d = 1'b0;
                    ctrl_d  = CTRL_CLR;
                    if (accept && is_mul) begin
                        state_d = MUL;
                        cnt_d   = CNT_W'(MUL_LATENCY - 1);
                    end else if (accept) begin
                        valid_d = 1'b1;
                        ctrl_d  = dec;
                    end
                end
                MUL: begin
                    // EX stays a bubble until the last MUL cycle issues the result command
                    if (cnt_q > CNT_W'(1)) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        valid_d = 1'b1;
                        ctrl_d  = CTRL_MUL;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_CLR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.busy         = (state_q == MUL);
    assign bus.ex_valid     = valid_q;
    assign bus.ex_cmd       = ctrl_q.cmd;
    assign bus.ex_wb_en     = ctrl_q.wb_en;
    assign bus.ex_mem_read  = ctrl_q.mem_read;
    assign bus.ex_mem_write = ctrl_q.mem_write;
    assign bus.ex_branch    = ctrl_q.branch;
    assign bus.ex_illegal   = ctrl_q.illegal;
endmodule
